moduldemo_arbiter: RTL and testbench
====================================

# moduldemo_arbiter

Round-robin arbiter sharing the single 8-bit/1-bit input port of one `MODULDEMO` instance between three requesters. Each winning requester gets an exclusive time slot of `HOLD_CYCLES` clocks. During the slot its data word and flag are registered once and presented, stable, to the shared port. Sits between the motion-control command sources and the demo datapath, in the 50 MHz `clk` domain.

## Interface
- `DATA_W`, 8, width of data words.
- `HOLD_CYCLES`, 4, slot length in clocks; legal 1..255; 8-bit internal counter.
- `IDLE_VALUE`, 8'h00, value driven on `out_data` when no slot is active.
- `clk`  in  1  system clock, 50 MHz, rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `req`  in  3  request per requester; level, held until `ack` or voluntarily dropped.
- `data_0`, `data_1`, `data_2`  in  DATA_W  requester data words.
- `flag_0`, `flag_1`, `flag_2`  in  1  requester 1-bit qualifiers.
- `gnt`  out  3  one-hot grant; all zero outside a slot.
- `ack`  out  3  one-clock pulse to the granted requester on the last slot cycle.
- `out_data`  out  DATA_W  shared port data to the demo module's 8-bit input.
- `out_flag`  out  1  shared port flag to the demo module's 1-bit input.
- `busy`  out  1  high in GRANT and RELEASE.

## Operation
- Reset values (`reset_n`=0 at a clock edge): state IDLE, `gnt`=0, `ack`=0, `out_data`=IDLE_VALUE, `out_flag`=0, `busy`=0, pointer `last`=2, so requester 0 has first priority.
- State machine: IDLE, GRANT, RELEASE. All outputs are registered.
- IDLE: if `req`≠0, select the first asserted requester in order `last`+1, `last`+2, `last`+3 (mod 3). On that edge:
  - set `gnt` one-hot;
  - capture `data_i` and `flag_i` into `out_data` and `out_flag`;
  - load the counter with `HOLD_CYCLES`-1;
  - set `last`=i;
  - go to GRANT.
- GRANT:
  - `out_data`/`out_flag` stay frozen at the captured values; later changes on `data_i` are ignored.
  - The counter decrements each cycle.
  - When the counter is 0 and `req[i]` is still high: `ack[i]`=1 for this one cycle, then go to RELEASE.
  - If `req[i]` is sampled low while in GRANT, the slot is aborted: no `ack`, go to RELEASE on the next edge. `last` keeps the aborted requester, so it loses priority.
- RELEASE: exactly one cycle with `gnt`=0, `ack`=0, `out_data`=IDLE_VALUE, `out_flag`=0, `busy`=1. This gives requesters one clock to drop `req` after `ack`. Then go to IDLE.
- Simultaneous requests are resolved only by the round-robin order. A requester that keeps `req` high after `ack` re-enters arbitration in the next IDLE, behind the other active requesters.
- Reset during GRANT or RELEASE: all outputs return to reset values on that edge. A pending `ack` is lost and `last` returns to 2.

## Timing
- `req` first sampled high in IDLE at edge N. `gnt`, `out_data` and `out_flag` are valid from N+1 through N+HOLD_CYCLES.
- `ack` is high in cycle N+HOLD_CYCLES, together with the last `gnt` cycle.
- RELEASE is cycle N+HOLD_CYCLES+1. IDLE is N+HOLD_CYCLES+2, and the next `gnt` starts at N+HOLD_CYCLES+3.
- Back-to-back slot period is HOLD_CYCLES+2 clocks.
- With HOLD_CYCLES=1, `gnt` and `ack` are both high in the single slot cycle.
- Abort: `req[i]` low sampled at edge M in GRANT gives `gnt`=0 from M+1.
- `out_data` never changes while a given `gnt` bit is high.

## Test plan
- Single request, defaults: `req`=3'b010, `data_1`=8'hAA, `flag_1`=1.
  - Expect `gnt`=3'b010 for 4 cycles with `out_data`=8'hAA and `out_flag`=1.
  - Expect `ack[1]` on the 4th cycle, then one RELEASE cycle with `out_data`=8'h00.
- Contention: `req`=3'b111 held, data 8'hAA/8'hCC/8'hEE.
  - Expect grant order 0,1,2,0 with matching data.
  - Expect slot spacing of 6 cycles.
- Data freeze: during the slot of requester 0, change `data_0` 8'hAA to 8'h55. `out_data` stays 8'hAA until RELEASE.
- Abort: drop `req[2]` on the 2nd GRANT cycle.
  - Expect `gnt`=0 one cycle later and no `ack[2]`.
  - Expect requester 0 to be granted next when `req`=3'b101.
- Reset mid-slot: pull `reset_n` low for 1 cycle during GRANT.
  - Expect all outputs at reset values next cycle.
  - Expect the first grant after reset with `req`=3'b111 to go to requester 0.
- `HOLD_CYCLES`=1 with `IDLE_VALUE`=8'hFF: expect single-cycle `gnt` and `ack`, and `out_data`=8'hFF in IDLE and RELEASE.

Source files
------------

// File: rtl/moduldemo_arbiter.sv
// Round-robin arbiter giving three requesters exclusive, fixed-length slots on
// the single data/flag input port of one MODULDEMO instance. All outputs are
// registered; the captured word and flag stay frozen for the whole slot.
module moduldemo_arbiter #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       HOLD_CYCLES = 4,
    parameter logic [DATA_W-1:0] IDLE_VALUE  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        req,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic              flag_0,
    input  logic              flag_1,
    input  logic              flag_2,
    output logic [2:0]        gnt,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_flag,
    output logic              busy
);

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [2:0]        ack_q, ack_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_flag_q, out_flag_d;
    logic              busy_q, busy_d;

    logic [1:0]        pick_idx;
    logic [DATA_W-1:0] pick_data;
    logic              pick_flag;

    // Round-robin pick: search starts at the requester after the last winner.
    always_comb begin
        pick_idx = 2'd0;
        case (last_q)
            2'd0: begin
                if (req[1])      pick_idx = 2'd1;
                else if (req[2]) pick_idx = 2'd2;
                else             pick_idx = 2'd0;
            end
            2'd1: begin
                if (req[2])      pick_idx = 2'd2;
                else if (req[0]) pick_idx = 2'd0;
                else             pick_idx = 2'd1;
            end
            default: begin
                if (req[0])      pick_idx = 2'd0;
                else if (req[1]) pick_idx = 2'd1;
                else             pick_idx = 2'd2;
            end
        endcase
    end

    // Route the winner's word and flag toward the capture registers.
    always_comb begin
        pick_data = data_0;
        pick_flag = flag_0;
        case (pick_idx)
            2'd1:    begin pick_data = data_1; pick_flag = flag_1; end
            2'd2:    begin pick_data = data_2; pick_flag = flag_2; end
            default: begin pick_data = data_0; pick_flag = flag_0; end
        endcase
    end

    // Next-state and next-output logic for the slot FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        ack_d      = 3'b000;
        out_data_d = out_data_q;
        out_flag_d = out_flag_q;
        busy_d     = busy_q;
        unique case (state_q)
            StIdle: begin
                gnt_d      = 3'b000;
                out_data_d = IDLE_VALUE;
                out_flag_d = 1'b0;
                busy_d     = 1'b0;
                if (|req) begin
                    state_d    = StGrant;
                    gnt_d      = 3'b001 << pick_idx;
                    out_data_d = pick_data;
                    out_flag_d = pick_flag;
                    cnt_d      = HoldLoad;
                    last_d     = pick_idx;
                    busy_d     = 1'b1;
                    // A one-cycle slot acks in its only cycle.
                    if (HoldLoad == 8'd0) ack_d = 3'b001 << pick_idx;
                end
            end
            StGrant: begin
                if ((req & gnt_q) == 3'b000 || cnt_q == 8'd0) begin
                    // Slot completed or aborted by the owner dropping req.
                    state_d    = StRelease;
                    gnt_d      = 3'b000;
                    out_data_d = IDLE_VALUE;
                    out_flag_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    // Registered ack must be set one edge before the last cycle.
                    if (cnt_q == 8'd1) ack_d = gnt_q;
                end
            end
            StRelease: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = StIdle;
                gnt_d      = 3'b000;
                out_data_d = IDLE_VALUE;
                out_flag_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            last_q     <= 2'd2;
            gnt_q      <= 3'b000;
            ack_q      <= 3'b000;
            out_data_q <= IDLE_VALUE;
            out_flag_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            out_data_q <= out_data_d;
            out_flag_q <= out_flag_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign out_data = out_data_q;
    assign out_flag = out_flag_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_moduldemo_arbiter.sv
// Scoreboard bench for moduldemo_arbiter: default instance plus a
// HOLD_CYCLES=1 / IDLE_VALUE=8'hFF instance.
module tb_moduldemo_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] req, req1;
    logic [7:0] data_0, data_1, data_2;
    logic       flag_0, flag_1, flag_2;
    logic [2:0] gnt, ack, gnt1, ack1;
    logic [7:0] out_data, out_data1;
    logic       out_flag, busy, out_flag1, busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [2:0] g;
        logic [7:0] d;
        logic       f;
    } slot_t;

    typedef struct {
        logic [2:0] g;
        logic [7:0] d;
        logic       f;
        int         len;
        int         ack_pos;
        logic [2:0] ack_val;
        logic       stable;
        logic [7:0] rel_d;
        logic       rel_f;
        logic [2:0] rel_ack;
        logic       rel_busy;
        int         start;
        logic       timeout;
    } obs_t;

    slot_t exp_q[$];
    slot_t e;
    obs_t  obs;

    moduldemo_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .data_0(data_0), .data_1(data_1), .data_2(data_2),
        .flag_0(flag_0), .flag_1(flag_1), .flag_2(flag_2),
        .gnt(gnt), .ack(ack), .out_data(out_data), .out_flag(out_flag), .busy(busy)
    );

    moduldemo_arbiter #(.DATA_W(8), .HOLD_CYCLES(1), .IDLE_VALUE(8'hFF)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req1),
        .data_0(data_0), .data_1(data_1), .data_2(data_2),
        .flag_0(flag_0), .flag_1(flag_1), .flag_2(flag_2),
        .gnt(gnt1), .ack(ack1), .out_data(out_data1), .out_flag(out_flag1), .busy(busy1)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Records one slot of the default instance; returns on the first cycle after it.
    task automatic observe_slot();
        int n = 0;
        obs.timeout = 1'b0; obs.stable = 1'b1; obs.len = 0;
        obs.ack_pos = 0;    obs.ack_val = 3'b000;
        while (gnt === 3'b000 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (gnt === 3'b000) begin
            obs.timeout = 1'b1;
            return;
        end
        obs.g = gnt; obs.d = out_data; obs.f = out_flag; obs.start = cyc;
        while (gnt !== 3'b000 && obs.len < 300) begin
            obs.len++;
            if (gnt !== obs.g || out_data !== obs.d || out_flag !== obs.f) obs.stable = 1'b0;
            if (ack !== 3'b000) begin
                obs.ack_pos = obs.len;
                obs.ack_val = ack;
            end
            @(negedge clk);
        end
        obs.rel_d = out_data; obs.rel_f = out_flag; obs.rel_ack = ack; obs.rel_busy = busy;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req = 3'b000;
        req1 = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (gnt !== 3'b000 || ack !== 3'b000 || out_data !== 8'h00 || out_flag !== 1'b0
            || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset got gnt=%b ack=%b data=%h flag=%b busy=%b required 000 000 00 0 0",
                     gnt, ack, out_data, out_flag, busy);
        end
        checks++;
        if (gnt1 !== 3'b000 || out_data1 !== 8'hFF || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold1 got gnt=%b data=%h busy=%b required 000 ff 0",
                     gnt1, out_data1, busy1);
        end
    endtask

    task automatic test_single();
        int c0;
        data_1 = 8'hAA; flag_1 = 1'b1;
        req = 3'b010;
        c0 = cyc;
        exp_q.push_back('{g: 3'b010, d: 8'hAA, f: 1'b1});
        observe_slot();
        req = 3'b000;
        e = exp_q.pop_front();
        checks++;
        if (obs.timeout || {obs.g, obs.d, obs.f} !== e) begin
            errors++;
            $display("FAIL single_slot got gnt=%b data=%h flag=%b required gnt=%b data=%h flag=%b",
                     obs.g, obs.d, obs.f, e.g, e.d, e.f);
        end
        checks++;
        if (obs.start - c0 !== 1) begin
            errors++;
            $display("FAIL single_latency got %0d required 1", obs.start - c0);
        end
        checks++;
        if (obs.len !== 4 || !obs.stable) begin
            errors++;
            $display("FAIL single_length got len=%0d stable=%b required 4 1", obs.len, obs.stable);
        end
        checks++;
        if (obs.ack_pos !== 4 || obs.ack_val !== 3'b010) begin
            errors++;
            $display("FAIL single_ack got pos=%0d ack=%b required 4 010", obs.ack_pos, obs.ack_val);
        end
        checks++;
        if (obs.rel_d !== 8'h00 || obs.rel_f !== 1'b0 || obs.rel_ack !== 3'b000
            || obs.rel_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_release got data=%h flag=%b ack=%b busy=%b required 00 0 000 1",
                     obs.rel_d, obs.rel_f, obs.rel_ack, obs.rel_busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL single_idle got busy=%b gnt=%b required 0 000", busy, gnt);
        end
    endtask

    task automatic test_contention();
        int prev = 0;
        apply_reset();
        data_0 = 8'hAA; data_1 = 8'hCC; data_2 = 8'hEE;
        flag_0 = 1'b1;  flag_1 = 1'b0;  flag_2 = 1'b1;
        req = 3'b111;
        exp_q.push_back('{g: 3'b001, d: 8'hAA, f: 1'b1});
        exp_q.push_back('{g: 3'b010, d: 8'hCC, f: 1'b0});
        exp_q.push_back('{g: 3'b100, d: 8'hEE, f: 1'b1});
        exp_q.push_back('{g: 3'b001, d: 8'hAA, f: 1'b1});
        for (int i = 0; i < 4; i++) begin
            observe_slot();
            if (i == 3) req = 3'b000;
            e = exp_q.pop_front();
            checks++;
            if (obs.timeout || {obs.g, obs.d, obs.f} !== e || obs.ack_val !== e.g) begin
                errors++;
                $display("FAIL contention_slot%0d got gnt=%b data=%h flag=%b ack=%b required gnt=%b data=%h flag=%b",
                         i, obs.g, obs.d, obs.f, obs.ack_val, e.g, e.d, e.f);
            end
            if (i > 0) begin
                checks++;
                if (obs.start - prev !== 6) begin
                    errors++;
                    $display("FAIL contention_spacing%0d got %0d required 6", i, obs.start - prev);
                end
            end
            prev = obs.start;
        end
    endtask

    task automatic test_data_freeze();
        apply_reset();
        data_0 = 8'hAA; flag_0 = 1'b1;
        req = 3'b001;
        exp_q.push_back('{g: 3'b001, d: 8'hAA, f: 1'b1});
        fork
            observe_slot();
            begin
                @(negedge clk);
                @(negedge clk);
                data_0 = 8'h55;
            end
        join
        req = 3'b000;
        e = exp_q.pop_front();
        checks++;
        if (obs.timeout || {obs.g, obs.d, obs.f} !== e || !obs.stable || obs.len !== 4) begin
            errors++;
            $display("FAIL freeze got gnt=%b data=%h stable=%b len=%0d required gnt=%b data=%h stable=1 len=4",
                     obs.g, obs.d, obs.stable, obs.len, e.g, e.d);
        end
        checks++;
        if (obs.rel_d !== 8'h00) begin
            errors++;
            $display("FAIL freeze_release got data=%h required 00", obs.rel_d);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        data_0 = 8'h11; flag_0 = 1'b0; data_2 = 8'hEE; flag_2 = 1'b1;
        req = 3'b100;
        exp_q.push_back('{g: 3'b100, d: 8'hEE, f: 1'b1});
        fork
            observe_slot();
            begin
                int k = 0;
                while (gnt !== 3'b100 && k < 40) begin
                    @(negedge clk);
                    k++;
                end
                @(negedge clk);
                req[2] = 1'b0;
            end
        join
        e = exp_q.pop_front();
        checks++;
        if (obs.timeout || {obs.g, obs.d, obs.f} !== e) begin
            errors++;
            $display("FAIL abort_slot got gnt=%b data=%h required gnt=%b data=%h",
                     obs.g, obs.d, e.g, e.d);
        end
        checks++;
        if (obs.len !== 2 || obs.ack_pos !== 0 || obs.rel_ack !== 3'b000) begin
            errors++;
            $display("FAIL abort_cut got len=%0d ack_pos=%0d required len=2 ack_pos=0",
                     obs.len, obs.ack_pos);
        end
        req = 3'b101;
        exp_q.push_back('{g: 3'b001, d: 8'h11, f: 1'b0});
        exp_q.push_back('{g: 3'b100, d: 8'hEE, f: 1'b1});
        for (int i = 0; i < 2; i++) begin
            observe_slot();
            if (i == 1) req = 3'b000;
            e = exp_q.pop_front();
            checks++;
            if (obs.timeout || {obs.g, obs.d, obs.f} !== e || obs.len !== 4) begin
                errors++;
                $display("FAIL abort_next%0d got gnt=%b data=%h len=%0d required gnt=%b data=%h len=4",
                         i, obs.g, obs.d, obs.len, e.g, e.d);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        apply_reset();
        data_0 = 8'hAA; data_1 = 8'hCC; data_2 = 8'hEE;
        flag_0 = 1'b1;  flag_1 = 1'b0;  flag_2 = 1'b1;
        req = 3'b111;
        exp_q.push_back('{g: 3'b001, d: 8'hAA, f: 1'b1});
        while (gnt === 3'b000 && k < 40) begin
            @(negedge clk);
            k++;
        end
        e = exp_q.pop_front();
        checks++;
        if ({gnt, out_data, out_flag} !== e) begin
            errors++;
            $display("FAIL resetmid_first got gnt=%b data=%h required gnt=%b data=%h",
                     gnt, out_data, e.g, e.d);
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (gnt !== 3'b000 || ack !== 3'b000 || out_data !== 8'h00 || out_flag !== 1'b0
            || busy !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_outputs got gnt=%b ack=%b data=%h flag=%b busy=%b required 000 000 00 0 0",
                     gnt, ack, out_data, out_flag, busy);
        end
        exp_q.push_back('{g: 3'b001, d: 8'hAA, f: 1'b1});
        observe_slot();
        req = 3'b000;
        e = exp_q.pop_front();
        checks++;
        if (obs.timeout || {obs.g, obs.d, obs.f} !== e) begin
            errors++;
            $display("FAIL resetmid_regrant got gnt=%b data=%h required gnt=%b data=%h",
                     obs.g, obs.d, e.g, e.d);
        end
    endtask

    task automatic test_hold1();
        int k = 0;
        apply_reset();
        data_1 = 8'hAA; flag_1 = 1'b1;
        req1 = 3'b010;
        exp_q.push_back('{g: 3'b010, d: 8'hAA, f: 1'b1});
        while (gnt1 === 3'b000 && k < 40) begin
            @(negedge clk);
            k++;
        end
        req1 = 3'b000;
        e = exp_q.pop_front();
        checks++;
        if ({gnt1, out_data1, out_flag1} !== e || ack1 !== 3'b010) begin
            errors++;
            $display("FAIL hold1_slot got gnt=%b ack=%b data=%h flag=%b required gnt=%b ack=010 data=%h flag=%b",
                     gnt1, ack1, out_data1, out_flag1, e.g, e.d, e.f);
        end
        @(negedge clk);
        checks++;
        if (gnt1 !== 3'b000 || ack1 !== 3'b000 || out_data1 !== 8'hFF || out_flag1 !== 1'b0
            || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL hold1_release got gnt=%b ack=%b data=%h flag=%b busy=%b required 000 000 ff 0 1",
                     gnt1, ack1, out_data1, out_flag1, busy1);
        end
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || out_data1 !== 8'hFF || gnt1 !== 3'b000) begin
            errors++;
            $display("FAIL hold1_idle got busy=%b data=%h gnt=%b required 0 ff 000",
                     busy1, out_data1, gnt1);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req = 3'b000; req1 = 3'b000;
        data_0 = 8'h00; data_1 = 8'h00; data_2 = 8'h00;
        flag_0 = 1'b0;  flag_1 = 1'b0;  flag_2 = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_data_freeze();
        test_abort();
        test_reset_mid();
        test_hold1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
